sample_sequencer: RTL

Schedules the 16-bit input sample fed to the delta-sigma PW modulator. Buffers host-written samples in a small FIFO and releases one sample every (rate_div+1) modulator pulses. Alternatively passes triangle-generator updates straight through. Sits between the register interface / triangle generator and the modulator's u input, replacing direct writes to the sample register.

---
 rtl/sample_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sample_sequencer.sv
// -----------------------------------------------------------------------------
// sample_sequencer
//   Chooses the 16-bit sample presented to the delta-sigma PW modulator.
//   FIFO mode (src_sel=0): host samples are queued in a small FIFO and one is
//   released every (rate_div+1) modulator pulses. Triangle mode (src_sel=1):
//   triangle-generator updates pass straight through to u_out.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   enable            sequencing active (divider runs, triangle grants allowed)
//   src_sel           0 = FIFO source, 1 = triangle source
//   pulse_done        one strobe per modulator PWM pulse
//   rate_div          release period minus one, in pulses
//   wr_valid/wr_data  host push request and sample
//   wr_ready          push accepted on wr_valid && wr_ready
//   flush             empty the FIFO
//   tri_valid/data    triangle update offer
//   tri_ready         triangle update consumed on tri_valid && tri_ready
//   u_out, u_load     current modulator sample, one-cycle strobe when it changes
//   fifo_level        entries held (0..depth)
//   underrun          sticky: a release tick found the FIFO empty
//   underrun_clr      clear underrun (a simultaneous set wins)
//
// Handshakes: a transfer happens on the clock edge where valid && ready are both
// high; ready never depends on valid, and valid may be held across cycles.
// -----------------------------------------------------------------------------
module sample_sequencer #(
   parameter int SAMPLE_BITS = 16,
   parameter int DEPTH_LOG2  = 2,
   parameter int DIV_BITS    = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   src_sel,
   input  logic                   pulse_done,
   input  logic [DIV_BITS-1:0]    rate_div,
   input  logic                   wr_valid,
   input  logic [SAMPLE_BITS-1:0] wr_data,
   output logic                   wr_ready,
   input  logic                   flush,
   input  logic                   tri_valid,
   input  logic [SAMPLE_BITS-1:0] tri_data,
   output logic                   tri_ready,
   output logic [SAMPLE_BITS-1:0] u_out,
   output logic                   u_load,
   output logic [DEPTH_LOG2:0]    fifo_level,
   output logic                   underrun,
   input  logic                   underrun_clr
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]    FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]    LVL_ONE    = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0]  PTR_ONE    = DEPTH_LOG2'(1);
   localparam logic [DIV_BITS-1:0]    CNT_ONE    = DIV_BITS'(1);
   localparam logic [SAMPLE_BITS-1:0] MIDSCALE   = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

   logic [DIV_BITS-1:0]    r_cnt;
   logic [SAMPLE_BITS-1:0] r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  r_wr_ptr;
   logic [DEPTH_LOG2-1:0]  r_rd_ptr;
   logic [DEPTH_LOG2:0]    r_level;
   logic [SAMPLE_BITS-1:0] r_u_out;
   logic                   r_u_load;
   logic                   r_underrun;

   logic                   w_full;
   logic                   w_empty;
   logic                   w_tick;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_tri_take;
   logic                   w_underrun_set;
   logic                   w_load;
   logic [SAMPLE_BITS-1:0] w_load_data;

   assign w_full  = (r_level == FULL_LEVEL);
   assign w_empty = (r_level == '0);

   // >= rather than == so that lowering rate_div below the running count
   // releases on the very next pulse instead of waiting for a wrap.
   assign w_tick = enable && pulse_done && (r_cnt >= rate_div);

   assign wr_ready  = !w_full && !flush;
   assign tri_ready = src_sel && enable;

   assign w_push         = wr_valid && wr_ready;
   assign w_pop          = w_tick && !src_sel && !w_empty && !flush;
   assign w_underrun_set = w_tick && !src_sel && w_empty;
   assign w_tri_take     = tri_valid && tri_ready;

   // src_sel makes pop and triangle take mutually exclusive.
   always_comb begin
      w_load      = 1'b0;
      w_load_data = r_u_out;
      if (w_pop) begin
         w_load      = 1'b1;
         w_load_data = r_mem[r_rd_ptr];
      end else if (w_tri_take) begin
         w_load      = 1'b1;
         w_load_data = tri_data;
      end
   end

   // Pulse divider: counts pulses while enabled, restarts on each tick.
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         r_cnt <= '0;
      end else if (pulse_done) begin
         if (w_tick) r_cnt <= '0;
         else        r_cnt <= r_cnt + CNT_ONE;
      end
   end

   // Storage needs no reset; the level/pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_push && !w_pop)      r_level <= r_level + LVL_ONE;
         else if (w_pop && !w_push) r_level <= r_level - LVL_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_u_out  <= MIDSCALE;
         r_u_load <= 1'b0;
      end else begin
         r_u_out  <= w_load_data;
         r_u_load <= w_load;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)               r_underrun <= 1'b0;
      else if (w_underrun_set) r_underrun <= 1'b1;
      else if (underrun_clr)   r_underrun <= 1'b0;
   end

   assign u_out      = r_u_out;
   assign u_load     = r_u_load;
   assign fifo_level = r_level;
   assign underrun   = r_underrun;

endmodule
